accel_cmd_regs: RTL and testbench
=================================

ACCEL_CMD_REGS -- requirements
Module: accel_cmd_regs

Interface
REQ-001 Parameter DATA_W, default 32: Avalon data width and width of every register; legal 8..64.
REQ-002 Parameter NUM_ARGS, default 4: accelerator argument registers; legal 1..16.
REQ-003 Parameter NUM_RETS, default 2: accelerator return registers; legal 1..16.
REQ-004 Parameter ADDR_W, default 16: Avalon word-address width.
REQ-005 Parameter TIMEOUT, default 0: maximum RUN cycles before forced stop; 0 disables the timeout.
REQ-006 clk  in  1  single clock; one clock, all logic on the rising edge.
REQ-007 reset  in  1  reset, synchronous and active-high.
REQ-008 avalon_slave_address  in  ADDR_W  word address.
REQ-009 avalon_slave_chipselect  in  1  slave select; no access without it.
REQ-010 avalon_slave_write  in  1  write strobe.
REQ-011 avalon_slave_read  in  1  read strobe.
REQ-012 avalon_slave_writedata  in  DATA_W  write data.
REQ-013 avalon_slave_readdata  out  DATA_W  registered read data.
REQ-014 accel_start  out  1  one-cycle start pulse to the accelerator.
REQ-015 accel_abort  out  1  one-cycle abort pulse to the accelerator.
REQ-016 accel_args  out  NUM_ARGS*DATA_W  argument registers, ARG0 in the LSBs.
REQ-017 accel_done  in  1  completion pulse from the accelerator.
REQ-018 accel_rets  in  NUM_RETS*DATA_W  return values, valid in the accel_done cycle.
REQ-019 irq  out  1  level interrupt; equals STATUS.done.

Function
REQ-020 Address map: 0 CMD (write-only, reads 0); 1 STATUS; 2 CYCLES (read-only); 3..3+NUM_ARGS-1 ARGn (read/write); next NUM_RETS addresses RETn (read-only); all other addresses read 0 and ignore writes.
REQ-021 A write occurs in a cycle where chipselect=1 and write=1; a read occurs where chipselect=1 and read=1, with read taking precedence if both are high.
REQ-022 readdata is updated one cycle after the read cycle and holds its value until the next read.
REQ-023 STATUS bits: [0] busy, [1] done, [2] timeout; other bits read 0; writing 1 to bit 1 clears done and timeout (W1C); writing 0 has no effect.
REQ-024 FSM states: IDLE, RUN, DONE; busy=1 only in RUN.
REQ-025 CMD write with bit0=1 in IDLE or DONE: move to RUN; assert accel_start in the next cycle for exactly one cycle; clear CYCLES, done and timeout.
REQ-026 CMD write with bit0=1 in RUN is ignored.
REQ-027 CMD write with bit1=1 in RUN: move to IDLE; pulse accel_abort for one cycle; done and timeout unchanged; RETn unchanged.
REQ-028 Bit1 takes precedence over bit0 when both are set, and is a no-op outside RUN.
REQ-029 In RUN, CYCLES increments every cycle, saturating at 2^DATA_W-1.
REQ-030 accel_done=1 in RUN: capture accel_rets into RETn in that edge; move to DONE; set done=1.
REQ-031 accel_done outside RUN is ignored.
REQ-032 TIMEOUT>0 and CYCLES==TIMEOUT-1 in RUN without accel_done: move to DONE; set done=1 and timeout=1; pulse accel_abort; RETn not captured.
REQ-033 accel_done in the same cycle as timeout expiry: the done behaviour wins and timeout stays 0.
REQ-034 ARGn writes are accepted in IDLE and DONE and ignored in RUN, keeping accel_args stable for the whole run.
REQ-035 A STATUS W1C write in the same cycle as a done event: the event wins and done is set.

Reset
REQ-036 reset=1 at a clock edge forces IDLE; all ARGn, RETn, CYCLES, STATUS bits and readdata go to 0; accel_start, accel_abort and irq go to 0.
REQ-037 Reset mid-RUN forces IDLE without an accel_abort pulse; the accelerator shares the reset.

Verification
REQ-038 Write ARG0=0x12, ARG1=0x34, then CMD=1 -> accel_start high for exactly one cycle; accel_args[63:0]=0x00000034_00000012; STATUS reads 0x1.
REQ-039 After 10 RUN cycles, drive accel_done with rets={0xBEEF,0xCAFE} -> STATUS=0x2, irq=1, RET0=0xCAFE, RET1=0xBEEF, CYCLES=10; W1C write of 0x2 -> STATUS=0, irq=0.
REQ-040 With TIMEOUT=8, issue start and never assert done -> 8 cycles later STATUS=0x6, one accel_abort pulse, RETn unchanged.
REQ-041 During RUN, write CMD=1 and ARG0=0xFF -> no second start; ARG0 keeps its old value. Then write CMD=3 -> state IDLE, one accel_abort pulse, STATUS=0.
REQ-042 With TIMEOUT=8, assert accel_done in the expiry cycle -> STATUS=0x2 with timeout=0 and RETn captured. Separately, assert reset mid-RUN -> all registers read 0 and accel_abort stays 0.
REQ-043 Read unmapped address 0x7F and CMD -> readdata=0 one cycle after the read.

Source files
------------

// File: rtl/accel_cmd_regs.sv
// Avalon-MM command/status register block for a start/done style accelerator.
// Holds argument and return registers, a run-cycle counter and an optional watchdog timeout.
module accel_cmd_regs #(
    parameter int DATA_W   = 32,
    parameter int NUM_ARGS = 4,
    parameter int NUM_RETS = 2,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            avalon_slave_address,
    input  logic                         avalon_slave_chipselect,
    input  logic                         avalon_slave_write,
    input  logic                         avalon_slave_read,
    input  logic [DATA_W-1:0]            avalon_slave_writedata,
    output logic [DATA_W-1:0]            avalon_slave_readdata,
    output logic                         accel_start,
    output logic                         accel_abort,
    output logic [NUM_ARGS*DATA_W-1:0]   accel_args,
    input  logic                         accel_done,
    input  logic [NUM_RETS*DATA_W-1:0]   accel_rets,
    output logic                         irq
);

    // state  | meaning
    // S_IDLE | no job; arguments writable
    // S_RUN  | job in flight; CYCLES counting, arguments frozen
    // S_DONE | job finished or timed out; results held
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] A_CMD    = '0;
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(2);
    localparam int                ARG_BASE = 3;
    localparam int                RET_BASE = 3 + NUM_ARGS;
    localparam bit                TO_EN    = (TIMEOUT > 0);
    localparam logic [DATA_W-1:0] TO_LAST  = TO_EN ? DATA_W'(TIMEOUT - 1) : '0;

    state_t state, state_nxt;

    logic [DATA_W-1:0] arg_q [NUM_ARGS];
    logic [DATA_W-1:0] ret_q [NUM_RETS];
    logic [DATA_W-1:0] cycles_q;
    logic [DATA_W-1:0] rd_mux;
    logic              done_q, timeout_q, start_q, abort_q;

    logic rd_en, wr_en, cmd_wr, status_wr, cmd_go, cmd_abort, expire;
    logic busy, start_evt, abort_evt, capture, set_done, set_timeout;

    // A simultaneous read and write is treated as a read only.
    assign rd_en     = avalon_slave_chipselect & avalon_slave_read;
    assign wr_en     = avalon_slave_chipselect & avalon_slave_write & ~avalon_slave_read;
    assign cmd_wr    = wr_en && (avalon_slave_address == A_CMD);
    assign status_wr = wr_en && (avalon_slave_address == A_STATUS);
    assign cmd_abort = cmd_wr & avalon_slave_writedata[1];
    assign cmd_go    = cmd_wr & avalon_slave_writedata[0] & ~avalon_slave_writedata[1];
    assign expire    = TO_EN && (cycles_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (cmd_go) state_nxt = S_RUN;
            S_RUN: begin
                if (accel_done)     state_nxt = S_DONE;
                else if (cmd_abort) state_nxt = S_IDLE;
                else if (expire)    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Completion beats a host abort, which beats the watchdog.
    always_comb begin
        busy        = (state == S_RUN);
        start_evt   = !busy && cmd_go;
        capture     = busy && accel_done;
        abort_evt   = busy && !accel_done && (cmd_abort || expire);
        set_timeout = busy && !accel_done && !cmd_abort && expire;
        set_done    = capture || set_timeout;
    end

    always_comb begin
        rd_mux = '0;
        if (avalon_slave_address == A_STATUS)
            rd_mux = DATA_W'({timeout_q, done_q, busy});
        else if (avalon_slave_address == A_CYCLES)
            rd_mux = cycles_q;
        for (int i = 0; i < NUM_ARGS; i++)
            if (avalon_slave_address == ADDR_W'(ARG_BASE + i)) rd_mux = arg_q[i];
        for (int i = 0; i < NUM_RETS; i++)
            if (avalon_slave_address == ADDR_W'(RET_BASE + i)) rd_mux = ret_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q               <= 1'b0;
            abort_q               <= 1'b0;
            cycles_q              <= '0;
            done_q                <= 1'b0;
            timeout_q             <= 1'b0;
            avalon_slave_readdata <= '0;
            for (int i = 0; i < NUM_ARGS; i++) arg_q[i] <= '0;
            for (int i = 0; i < NUM_RETS; i++) ret_q[i] <= '0;
        end else begin
            start_q <= start_evt;
            abort_q <= abort_evt;

            if (start_evt)
                cycles_q <= '0;
            else if (busy && (cycles_q != '1))
                cycles_q <= cycles_q + 1'b1;

            // A done event outranks a same-cycle W1C clear.
            if (start_evt) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else if (set_done) begin
                done_q    <= 1'b1;
                timeout_q <= set_timeout;
            end else if (status_wr && avalon_slave_writedata[1]) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (capture)
                for (int i = 0; i < NUM_RETS; i++) ret_q[i] <= accel_rets[i*DATA_W +: DATA_W];

            for (int i = 0; i < NUM_ARGS; i++)
                if (wr_en && !busy && (avalon_slave_address == ADDR_W'(ARG_BASE + i)))
                    arg_q[i] <= avalon_slave_writedata;

            if (rd_en) avalon_slave_readdata <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
        assign accel_args[g*DATA_W +: DATA_W] = arg_q[g];
    end

    assign accel_start = start_q;
    assign accel_abort = abort_q;
    assign irq         = done_q;

endmodule

// File: tb/tb_accel_cmd_regs.sv
// Scoreboard bench for accel_cmd_regs: directed scenarios followed by random traffic,
// all checked against a register-level reference model.
module tb_accel_cmd_regs;
    localparam int DW = 32;
    localparam int NA = 4;
    localparam int NR = 2;
    localparam int AW = 16;
    localparam int TO = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     address = '0;
    logic              chipselect = 1'b0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [DW-1:0]     writedata = '0;
    logic [DW-1:0]     readdata;
    logic              accel_start, accel_abort, accel_done = 1'b0, irq;
    logic [NA*DW-1:0]  accel_args;
    logic [NR*DW-1:0]  accel_rets = '0;

    always #5 clk = ~clk;

    accel_cmd_regs #(.DATA_W(DW), .NUM_ARGS(NA), .NUM_RETS(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .avalon_slave_address    (address),
        .avalon_slave_chipselect (chipselect),
        .avalon_slave_write      (write),
        .avalon_slave_read       (read),
        .avalon_slave_writedata  (writedata),
        .avalon_slave_readdata   (readdata),
        .accel_start             (accel_start),
        .accel_abort             (accel_abort),
        .accel_args              (accel_args),
        .accel_done              (accel_done),
        .accel_rets              (accel_rets),
        .irq                     (irq)
    );

    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    logic [31:0] m_args [NA];
    logic [31:0] m_rets [NR];
    logic [31:0] m_cycles = '0;
    bit          m_done = 0, m_to = 0;

    logic [31:0] rd_q[$];
    int          start_q[$];
    int          abort_q[$];
    int          cyc = 0, n_pass = 0, n_chk = 0;
    bit          s_rd = 0, s_rst = 0, armed = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int ai = int'(a);
        if (ai == 1) return {29'b0, m_to, m_done, m_mode == M_RUN};
        if (ai == 2) return m_cycles;
        if (ai >= 3 && ai < 3 + NA) return m_args[ai-3];
        if (ai >= 3 + NA && ai < 3 + NA + NR) return m_rets[ai-3-NA];
        return '0;
    endfunction

    // Drive one cycle of inputs, predict the register file after the edge, then commit.
    task automatic step(input bit rst, input bit c, input bit w, input bit r, input logic [15:0] a,
                        input logic [31:0] d, input bit dn, input logic [63:0] rt,
                        input bit use_exp, input logic [31:0] exp);
        mode_t       n_mode;
        logic [31:0] n_args [NA];
        logic [31:0] n_rets [NR];
        logic [31:0] n_cycles;
        bit          n_done, n_to, wr_ok, rd_ok;
        int          ai;
        reset = rst; chipselect = c; write = w; read = r; address = a; writedata = d;
        accel_done = dn; accel_rets = rt;
        n_mode = m_mode; n_args = m_args; n_rets = m_rets; n_cycles = m_cycles;
        n_done = m_done; n_to = m_to;
        wr_ok = c && w && !r; rd_ok = c && r; ai = int'(a);
        if (rst) begin
            n_mode = M_IDLE; n_cycles = '0; n_done = 0; n_to = 0;
            foreach (n_args[i]) n_args[i] = '0;
            foreach (n_rets[i]) n_rets[i] = '0;
        end else begin
            if (rd_ok) rd_q.push_back(use_exp ? exp : model_read(a));
            if (m_mode == M_RUN) begin
                if (m_cycles != 32'hFFFF_FFFF) n_cycles = m_cycles + 1;
                if (dn) begin
                    n_mode = M_DONE; n_done = 1; n_to = 0;
                    n_rets[0] = rt[31:0]; n_rets[1] = rt[63:32];
                end else if (wr_ok && ai == 0 && d[1]) begin
                    n_mode = M_IDLE; abort_q.push_back(cyc + 1);
                end else if (TO > 0 && m_cycles == 32'(TO - 1)) begin
                    n_mode = M_DONE; n_done = 1; n_to = 1; abort_q.push_back(cyc + 1);
                end else if (wr_ok && ai == 1 && d[1]) begin
                    n_done = 0; n_to = 0;
                end
            end else begin
                if (wr_ok && ai == 0 && d[0] && !d[1]) begin
                    n_mode = M_RUN; n_cycles = '0; n_done = 0; n_to = 0;
                    start_q.push_back(cyc + 1);
                end else if (wr_ok && ai == 1 && d[1]) begin
                    n_done = 0; n_to = 0;
                end
                if (wr_ok && ai >= 3 && ai < 3 + NA) n_args[ai-3] = d;
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_args = n_args; m_rets = n_rets; m_cycles = n_cycles;
        m_done = n_done; m_to = n_to;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        step(0, 1, 1, 0, a, d, 0, '0, 0, '0);
    endtask
    task automatic rd(input logic [15:0] a);
        step(0, 1, 0, 1, a, '0, 0, '0, 0, '0);
    endtask
    task automatic rd_exp(input logic [15:0] a, input logic [31:0] e);
        step(0, 1, 0, 1, a, '0, 0, '0, 1, e);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0, '0, 0, '0);
    endtask
    task automatic done_cyc(input logic [63:0] rt);
        step(0, 0, 0, 0, '0, '0, 1, rt, 0, '0);
    endtask
    task automatic rst_cyc();
        step(1, 0, 0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    always @(posedge clk) begin
        cyc++;
        s_rd  = chipselect && read && !reset;
        s_rst = reset;
    end

    always @(negedge clk) begin
        logic [127:0] exp_args;
        if (s_rst) armed = 1;
        if (armed) begin
            if (s_rst) last_rd = '0;
            if (s_rd) begin
                if (rd_q.size() == 0) chk("readdata_unexpected", 128'(readdata), 128'hDEAD);
                else begin
                    last_rd = rd_q.pop_front();
                    chk("readdata", 128'(readdata), 128'(last_rd));
                end
            end else begin
                chk("readdata_hold", 128'(readdata), 128'(last_rd));
            end
            if (accel_start) begin
                if (start_q.size() == 0) chk("start_unexpected", 128'(cyc), 128'hFFFF);
                else chk("start_cycle", 128'(cyc), 128'(start_q.pop_front()));
            end
            if (accel_abort) begin
                if (abort_q.size() == 0) chk("abort_unexpected", 128'(cyc), 128'hFFFF);
                else chk("abort_cycle", 128'(cyc), 128'(abort_q.pop_front()));
            end
            chk("irq", 128'(irq), 128'(m_done));
            exp_args = '0;
            for (int i = 0; i < NA; i++) exp_args[i*32 +: 32] = m_args[i];
            chk("accel_args", 128'(accel_args), exp_args);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pick, op;
        logic [15:0] a;
        logic [31:0] d;
        foreach (m_args[i]) m_args[i] = '0;
        foreach (m_rets[i]) m_rets[i] = '0;
        rst_cyc();
        rst_cyc();
        rd_exp(1, 0); rd_exp(2, 0); rd_exp(3, 0);

        // Start with two arguments, run ten cycles, complete.
        wr(3, 32'h12); wr(4, 32'h34); wr(0, 1);
        rd_exp(1, 32'h1);
        chk("args_lo64", 128'(accel_args[63:0]), 128'h00000034_00000012);
        idle(8);
        done_cyc({32'hBEEF, 32'hCAFE});
        rd_exp(1, 32'h2); rd_exp(7, 32'hCAFE); rd_exp(8, 32'hBEEF); rd_exp(2, 32'd10);
        chk("irq_after_done", 128'(irq), 128'(1));
        wr(1, 32'h2);
        rd_exp(1, 32'h0);
        chk("irq_after_w1c", 128'(irq), 128'(0));

        // Writes during RUN are ignored; CMD=3 aborts.
        wr(0, 1); wr(0, 1); wr(3, 32'hFF);
        rd_exp(3, 32'h12);
        wr(0, 3);
        rd_exp(1, 32'h0);

        // Watchdog expiry.
        wr(0, 1); idle(TO);
        rd_exp(1, 32'h6); rd_exp(7, 32'hCAFE); rd_exp(8, 32'hBEEF); rd(2);

        // Completion in the expiry cycle wins over the timeout.
        wr(1, 32'h2); wr(0, 1); idle(TO - 1);
        done_cyc({32'h2222, 32'h1111});
        rd_exp(1, 32'h2); rd_exp(7, 32'h1111); rd_exp(8, 32'h2222);

        // Reset in the middle of a run.
        wr(3, 32'hA5); wr(0, 1); idle(3); rst_cyc();
        rd_exp(1, 0); rd_exp(2, 0); rd_exp(3, 0); rd_exp(7, 0); rd_exp(8, 0);

        // Unmapped and write-only reads, and a deselected write.
        wr(3, 32'h5); rd_exp(3, 32'h5); rd_exp(16'h7F, 0); rd_exp(3, 32'h5); rd_exp(0, 0);
        step(0, 0, 1, 0, 16'd3, 32'h9, 0, '0, 0, '0);
        rd_exp(3, 32'h5);

        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 11);
            a = (pick < 10) ? 16'(pick) : ((pick == 10) ? 16'h7F : 16'($urandom));
            d = (a < 2) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            op = $urandom_range(0, 99);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                 (op < 30) || (op >= 60 && op < 65), (op >= 30 && op < 65), a, d,
                 $urandom_range(0, 19) == 0, {32'($urandom), 32'($urandom)}, 0, '0);
        end

        idle(3);
        chk("start_q_drained", 128'(start_q.size()), 128'(0));
        chk("abort_q_drained", 128'(abort_q.size()), 128'(0));
        chk("read_q_drained", 128'(rd_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
